// File: rtl/lsu_arbiter_ipa_if.sv
// Memory-side request/grant/response bus between the LSU arbiter and the cluster data memory port.
interface lsu_arbiter_ipa_if #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
);
  logic                  req;
  logic                  wen;
  logic [AWIDTH-1:0]     addr;
  logic [DWIDTH-1:0]     wdata;
  logic [DWIDTH/8-1:0]   be;
  logic                  gnt;
  logic                  rvalid;
  logic [DWIDTH-1:0]     rdata;

  modport master (
    output req, wen, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, wen, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/lsu_arbiter_ipa.sv
// Round-robin load/store arbiter: many CGRA tiles onto one OBI-style memory master port, with an
// in-order outstanding-ID FIFO that routes load responses back to the requesting tile.
module lsu_arbiter_ipa #(
  parameter int unsigned NB_TILES        = 16,
  parameter int unsigned AWIDTH          = 32,
  parameter int unsigned DWIDTH          = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [NB_TILES-1:0]          Tile_Req_I,
  input  logic [NB_TILES-1:0]          Tile_Wen_I,
  input  logic [NB_TILES*AWIDTH-1:0]   Tile_Addr_I,
  input  logic [NB_TILES*DWIDTH-1:0]   Tile_Wdata_I,
  output logic [NB_TILES-1:0]          Tile_Grant_O,
  output logic [NB_TILES-1:0]          Tile_Rvalid_O,
  output logic [DWIDTH-1:0]            Tile_Rdata_O,
  lsu_arbiter_ipa_if.master            mem_io,
  output logic                         Protocol_Err_O
);

  localparam int unsigned IDW  = (NB_TILES > 1) ? $clog2(NB_TILES) : 1;
  localparam int unsigned PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNTW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IDW:0]    NbTilesW = (IDW + 1)'(NB_TILES);
  localparam logic [IDW-1:0]  LastId   = IDW'(NB_TILES - 1);
  localparam logic [PTRW-1:0] LastPtr  = PTRW'(MAX_OUTSTANDING - 1);
  localparam logic [CNTW-1:0] MaxCnt   = CNTW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           wen;
  } fifo_entry_t;

  logic [NB_TILES-1:0] busy_q, busy_d, eligible;
  logic [IDW-1:0]      rr_q, rr_d, win_id;
  logic [IDW:0]        scan;
  logic                win_found;

  logic                slot_valid_q, slot_valid_d;
  logic                slot_wen_q, slot_wen_d;
  logic [IDW-1:0]      slot_id_q, slot_id_d;
  logic [AWIDTH-1:0]   slot_addr_q, slot_addr_d;
  logic [DWIDTH-1:0]   slot_wdata_q, slot_wdata_d;

  fifo_entry_t         fifo_mem_q [MAX_OUTSTANDING];
  fifo_entry_t         head;
  logic [PTRW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]     cnt_q, cnt_d;

  logic                mem_req, accept, pop, load_slot;
  logic [NB_TILES-1:0] grant_q, grant_d, rvalid_q, rvalid_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == LastPtr) ? '0 : p + PTRW'(1);
  endfunction

  // First eligible tile scanning upward from rr_q, wrapping at NB_TILES.
  always_comb begin
    eligible  = Tile_Req_I & ~busy_q;
    win_found = 1'b0;
    win_id    = '0;
    scan      = '0;
    for (int k = 0; k < NB_TILES; k++) begin
      scan = {1'b0, rr_q} + k[IDW:0];
      if (scan >= NbTilesW) scan = scan - NbTilesW;
      if (!win_found && eligible[scan[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan[IDW-1:0];
      end
    end
  end

  assign mem_req   = slot_valid_q && (cnt_q < MaxCnt);
  assign accept    = mem_req && mem_io.gnt;
  assign pop       = mem_io.rvalid && (cnt_q != '0);
  assign load_slot = !slot_valid_q || accept;
  assign head      = fifo_mem_q[rd_ptr_q];

  always_comb begin
    busy_d       = busy_q & Tile_Req_I;
    rr_d         = rr_q;
    slot_valid_d = slot_valid_q;
    slot_wen_d   = slot_wen_q;
    slot_id_d    = slot_id_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    if (load_slot) begin
      slot_valid_d = win_found;
      if (win_found) begin
        busy_d[win_id] = 1'b1;
        rr_d           = (win_id == LastId) ? '0 : win_id + IDW'(1);
        slot_wen_d     = Tile_Wen_I[win_id];
        slot_id_d      = win_id;
        slot_addr_d    = Tile_Addr_I[AWIDTH*int'(win_id) +: AWIDTH];
        slot_wdata_d   = Tile_Wdata_I[DWIDTH*int'(win_id) +: DWIDTH];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase

    grant_d = '0;
    if (accept) grant_d[slot_id_q] = 1'b1;

    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (pop && !head.wen) begin
      rvalid_d[head.id] = 1'b1;
      rdata_d           = mem_io.rdata;
    end

    // A response with nothing outstanding is dropped but remembered.
    err_d = err_q | (mem_io.rvalid && (cnt_q == '0));
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      busy_q       <= '0;
      rr_q         <= '0;
      slot_valid_q <= 1'b0;
      slot_wen_q   <= 1'b0;
      slot_id_q    <= '0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      grant_q      <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_mem_q[i] <= '0;
    end else begin
      busy_q       <= busy_d;
      rr_q         <= rr_d;
      slot_valid_q <= slot_valid_d;
      slot_wen_q   <= slot_wen_d;
      slot_id_q    <= slot_id_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      if (accept) begin
        fifo_mem_q[wr_ptr_q] <= {slot_id_q, slot_wen_q};
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  assign mem_io.req     = mem_req;
  assign mem_io.wen     = slot_wen_q;
  assign mem_io.addr    = slot_addr_q;
  assign mem_io.wdata   = slot_wdata_q;
  assign mem_io.be      = '1;
  assign Tile_Grant_O   = grant_q;
  assign Tile_Rvalid_O  = rvalid_q;
  assign Tile_Rdata_O   = rdata_q;
  assign Protocol_Err_O = err_q;

endmodule

// File: tb/tb_lsu_arbiter_ipa.sv
// Bench for lsu_arbiter_ipa: directed scenarios with literal expectations plus random traffic,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_lsu_arbiter_ipa;
  localparam int NB  = 16;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAX = 2;

  logic              Clk;
  logic              Reset;
  logic [NB-1:0]     Tile_Req_I, Tile_Wen_I;
  logic [NB*AW-1:0]  Tile_Addr_I;
  logic [NB*DW-1:0]  Tile_Wdata_I;
  logic [NB-1:0]     Tile_Grant_O, Tile_Rvalid_O;
  logic [DW-1:0]     Tile_Rdata_O;
  logic              Protocol_Err_O;

  lsu_arbiter_ipa_if #(.AWIDTH(AW), .DWIDTH(DW)) mem_if ();

  lsu_arbiter_ipa #(
    .NB_TILES(NB), .AWIDTH(AW), .DWIDTH(DW), .MAX_OUTSTANDING(MAX)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .Tile_Req_I(Tile_Req_I), .Tile_Wen_I(Tile_Wen_I),
    .Tile_Addr_I(Tile_Addr_I), .Tile_Wdata_I(Tile_Wdata_I),
    .Tile_Grant_O(Tile_Grant_O), .Tile_Rvalid_O(Tile_Rvalid_O),
    .Tile_Rdata_O(Tile_Rdata_O), .mem_io(mem_if), .Protocol_Err_O(Protocol_Err_O)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model (transaction level) ----------------
  logic [NB-1:0] m_busy, m_grant, m_rvalid;
  int            m_rr, m_sid;
  bit            m_sv, m_swen, m_err;
  logic [31:0]   m_saddr, m_swdata, m_rdata;
  int            m_outq[$];   // entries are id*2 + wen, oldest first

  function automatic void model_reset();
    m_busy = '0; m_grant = '0; m_rvalid = '0; m_rdata = '0;
    m_rr = 0; m_sid = 0; m_sv = 0; m_swen = 0; m_err = 0;
    m_saddr = '0; m_swdata = '0;
    m_outq.delete();
  endfunction

  function automatic bit model_step();
    bit mreq, acc;
    int w, idx, e;
    mreq = m_sv && (m_outq.size() < MAX);
    acc  = mreq && mem_if.gnt;
    w    = -1;
    m_grant = '0;
    if (acc) m_grant[m_sid] = 1'b1;
    m_rvalid = '0;
    if (mem_if.rvalid) begin
      if (m_outq.size() == 0) m_err = 1;
      else begin
        e = m_outq.pop_front();
        if (e % 2 == 0) begin
          m_rvalid[e / 2] = 1'b1;
          m_rdata = mem_if.rdata;
        end
      end
    end
    if (acc) m_outq.push_back(m_sid * 2 + int'(m_swen));
    if (!m_sv || acc) begin
      for (int k = 0; k < NB; k++) begin
        idx = (m_rr + k) % NB;
        if (w < 0 && Tile_Req_I[idx] && !m_busy[idx]) w = idx;
      end
      if (w >= 0) begin
        m_sv = 1; m_sid = w; m_swen = Tile_Wen_I[w];
        m_saddr = Tile_Addr_I[w*AW +: AW]; m_swdata = Tile_Wdata_I[w*DW +: DW];
        m_rr = (w + 1) % NB;
      end else m_sv = 0;
    end
    for (int i = 0; i < NB; i++) if (!Tile_Req_I[i]) m_busy[i] = 1'b0;
    if (w >= 0) m_busy[w] = 1'b1;
    return acc;
  endfunction

  // Single compare process: DUT state after each edge versus the model.
  always @(posedge Clk) begin
    bit mreq;
    #1;
    mreq = m_sv && (m_outq.size() < MAX);
    chk("mem_req", mem_if.req, mreq);
    if (mreq) begin
      chk("mem_addr", mem_if.addr, m_saddr);
      chk("mem_wdata", mem_if.wdata, m_swdata);
      chk("mem_wen", mem_if.wen, m_swen);
    end
    chk("mem_be", mem_if.be, 4'hF);
    chk("tile_grant", Tile_Grant_O, m_grant);
    chk("tile_rvalid", Tile_Rvalid_O, m_rvalid);
    chk("tile_rdata", Tile_Rdata_O, m_rdata);
    chk("protocol_err", Protocol_Err_O, m_err);
  end

  // ---------------- stimulus: tiles and memory ----------------
  int          t_state[NB];   // 0 idle, 1 waiting, 2 hold after grant, 3 forced low
  logic [31:0] t_addr[NB], t_wdata[NB];
  bit          t_wen[NB];
  int          pending[$];    // due cycle of each accepted transaction
  int          cyc = 0;
  bit          rand_mode = 0, gnt_force = 0, rv_force = 0, fixed_rd = 0;
  int          mem_delay = 1;
  logic [31:0] fixed_data = '0;

  task automatic tile_request(input int i, input logic [31:0] a, input bit w,
                              input logic [31:0] d);
    t_state[i] = 1; t_addr[i] = a; t_wen[i] = w; t_wdata[i] = d;
  endtask

  task automatic tick();
    bit due;
    if (!Reset) begin
      for (int i = 0; i < NB; i++) t_state[i] = 0;
      pending.delete();
    end
    for (int i = 0; i < NB; i++) begin
      case (t_state[i])
        1: if (m_grant[i]) t_state[i] = 2;
        2: t_state[i] = 3;
        3: t_state[i] = 0;
        default: ;
      endcase
      if (rand_mode && Reset && t_state[i] == 0 && $urandom_range(0, 99) < 30)
        tile_request(i, $urandom(), 1'($urandom_range(0, 1)), $urandom());
      Tile_Req_I[i]            = (t_state[i] == 1 || t_state[i] == 2);
      Tile_Wen_I[i]            = t_wen[i];
      Tile_Addr_I[i*AW +: AW]  = t_addr[i];
      Tile_Wdata_I[i*DW +: DW] = t_wdata[i];
    end
    due = (pending.size() > 0) && (pending[0] <= cyc);
    mem_if.gnt    = rand_mode ? ($urandom_range(0, 3) != 0) : gnt_force;
    mem_if.rvalid = rv_force || due;
    mem_if.rdata  = fixed_rd ? fixed_data : $urandom();
    if (!Reset) model_reset();
    else begin
      if (due) void'(pending.pop_front());
      if (model_step())
        pending.push_back(cyc + (rand_mode ? int'($urandom_range(1, 4)) : mem_delay));
    end
    cyc++;
    @(negedge Clk);
  endtask

  task automatic do_reset();
    rand_mode = 0; rv_force = 0;
    Reset = 1'b0;
    tick(); tick();
    Reset = 1'b1;
  endtask

  initial begin
    int rv_seen;
    for (int i = 0; i < NB; i++) begin
      t_state[i] = 0; t_addr[i] = '0; t_wdata[i] = '0; t_wen[i] = 0;
    end
    Tile_Req_I = '0; Tile_Wen_I = '0; Tile_Addr_I = '0; Tile_Wdata_I = '0;
    mem_if.gnt = 0; mem_if.rvalid = 0; mem_if.rdata = '0;
    model_reset();
    Reset = 1'b0;
    do_reset();

    // Single load from tile 3.
    gnt_force = 1; mem_delay = 1; fixed_rd = 1; fixed_data = 32'hDEADBEEF;
    tile_request(3, 32'h40, 0, 32'h0);
    tick();
    chk("t1_mem_req", mem_if.req, 1);
    chk("t1_mem_addr", mem_if.addr, 32'h40);
    chk("t1_mem_wen", mem_if.wen, 0);
    tick();
    chk("t1_grant", Tile_Grant_O, 16'h0008);
    tick();
    chk("t1_rvalid", Tile_Rvalid_O, 16'h0008);
    chk("t1_rdata", Tile_Rdata_O, 32'hDEADBEEF);
    tick(); tick();

    // Round-robin across tiles 0, 5, 15.
    do_reset();
    gnt_force = 1; mem_delay = 1; fixed_rd = 0;
    tile_request(0, 32'h1000, 0, 32'h0);
    tile_request(5, 32'h1004, 0, 32'h0);
    tile_request(15, 32'h1008, 0, 32'h0);
    tick(); tick();
    chk("t2_grant_a", Tile_Grant_O, 16'h0001);
    tick();
    chk("t2_grant_b", Tile_Grant_O, 16'h0020);
    tick();
    chk("t2_grant_c", Tile_Grant_O, 16'h8000);
    tick();
    chk("t2_no_regrant_a", Tile_Grant_O, 16'h0000);
    tick();
    chk("t2_no_regrant_b", Tile_Grant_O, 16'h0000);
    tick(); tick();

    // Store under backpressure from tile 2.
    do_reset();
    gnt_force = 0; mem_delay = 1;
    tile_request(2, 32'h80, 1, 32'h1234);
    tick();
    for (int c = 0; c < 4; c++) begin
      chk("t3_req_stable", mem_if.req, 1);
      chk("t3_addr_stable", mem_if.addr, 32'h80);
      chk("t3_wdata_stable", mem_if.wdata, 32'h1234);
      chk("t3_wen", mem_if.wen, 1);
      chk("t3_no_early_grant", Tile_Grant_O, 16'h0);
      tick();
    end
    gnt_force = 1;
    tick();
    chk("t3_grant", Tile_Grant_O, 16'h0004);
    tick();
    chk("t3_store_silent_a", Tile_Rvalid_O, 16'h0);
    tick();
    chk("t3_store_silent_b", Tile_Rvalid_O, 16'h0);

    // Outstanding limit with slow responses.
    do_reset();
    gnt_force = 1; mem_delay = 5;
    tile_request(1, 32'h100, 0, 32'h0);
    tile_request(2, 32'h104, 0, 32'h0);
    tile_request(3, 32'h108, 0, 32'h0);
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c >= 3 && c <= 6) chk("t4_req_blocked", mem_if.req, 0);
      if (c == 7) begin
        chk("t4_req_resume", mem_if.req, 1);
        chk("t4_resume_addr", mem_if.addr, 32'h108);
        chk("t4_rvalid_1", Tile_Rvalid_O, 16'h0002);
      end
      if (c == 8) chk("t4_rvalid_2", Tile_Rvalid_O, 16'h0004);
      if (c == 13) chk("t4_rvalid_3", Tile_Rvalid_O, 16'h0008);
    end

    // Stray response, then reset with a load in flight.
    do_reset();
    gnt_force = 1; mem_delay = 20;
    rv_force = 1;
    tick();
    rv_force = 0;
    chk("t5_err_set", Protocol_Err_O, 1);
    chk("t5_err_no_rvalid", Tile_Rvalid_O, 16'h0);
    tick();
    chk("t5_err_sticky", Protocol_Err_O, 1);
    tile_request(7, 32'h200, 0, 32'h0);
    tick(); tick(); tick();
    Reset = 1'b0;
    tick(); tick();
    chk("t5_rst_grant", Tile_Grant_O, 16'h0);
    chk("t5_rst_rvalid", Tile_Rvalid_O, 16'h0);
    chk("t5_rst_rdata", Tile_Rdata_O, 32'h0);
    chk("t5_rst_req", mem_if.req, 0);
    chk("t5_rst_addr", mem_if.addr, 32'h0);
    chk("t5_rst_wdata", mem_if.wdata, 32'h0);
    chk("t5_rst_wen", mem_if.wen, 0);
    chk("t5_rst_be", mem_if.be, 4'hF);
    chk("t5_rst_err", Protocol_Err_O, 0);
    Reset = 1'b1;
    rv_seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (Tile_Rvalid_O != 16'h0) rv_seen++;
    end
    chk("t5_no_resp_after_reset", rv_seen, 0);
    chk("t5_err_clear", Protocol_Err_O, 0);

    // Random traffic.
    do_reset();
    rand_mode = 1; fixed_rd = 0;
    repeat (3000) tick();
    rand_mode = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
